afu_csr_ctrl_bank: RTL and testbench
====================================

// Module: afu_csr_ctrl_bank
// PURPOSE
//  Parametrised CSR control/status bank between the CSR manager and afu_manager.
//  Decodes config writes: run/soft-reset/workspace, per-channel start/stop/reset.
//  Serves counter, status and info readback, tracks outstanding CCI reads/writes
//  and throttles new requests. Adds a RUN->DRAIN->IDLE shutdown sequence.
// PARAMETERS
//  NUM_CH       64  channels in start/reset masks (1..64)
//  INFO_WORDS   9   64-bit info words readable at rd idx 4..4+INFO_WORDS-1
//  MAX_OUT      64  max outstanding reads, and separately max outstanding writes
//  RST_CYCLES   4   per-channel reset pulse length in cycles (>=1)
//  IDX_W        4   CSR index width
// PORTS
//  clk          in   1             clock
//  reset        in   1             reset, synchronous, active-high
//  csr_wr_en    in   1             CSR write strobe
//  csr_wr_idx   in   IDX_W         CSR write index
//  csr_wr_data  in   64            CSR write data
//  csr_rd_idx   in   IDX_W         CSR read index
//  csr_rd_data  out  64            read data, registered, 1-cycle latency
//  info         in   64*INFO_WORDS status words from afu_manager
//  rd_req_fire  in   1             read request issued this cycle
//  rd_rsp       in   1             read response received
//  wr_req_fire  in   1             write request issued this cycle
//  wr_rsp       in   1             write response received
//  run          out  1             high only in RUN
//  soft_rst     out  1             CFG bit1 level, ORed into afu_manager reset
//  update_ws    out  1             1-cycle pulse on CFG write with bit2 set
//  ws_base      out  64            workspace byte base address
//  ws_size      out  64            workspace size word
//  start_mask   out  NUM_CH        per-channel start enables
//  ch_rst       out  NUM_CH        per-channel reset, stretched RST_CYCLES
//  rd_ok / wr_ok out 1 each        request may be issued this cycle
// BEHAVIOUR
//  Reset: every output, register, counter and shadow is 0; state=IDLE.
//  Write map: 0 CFG{b0 run, b1 soft_rst, b2 update_ws}; 1 WS_BASE; 2 WS_SIZE.
//   3 START_SET: mask |= d. 4 START_CLR: mask &= ~d. 5 RST_CH. 6 SNAPSHOT.
//   Writes take effect the cycle after csr_wr_en. Unmapped indices are ignored.
//   Only one index is written per cycle, so SET and CLR cannot collide.
//   Data bits at and above NUM_CH are ignored.
//  FSM IDLE: CFG b0=1 -> RUN and clear the done sticky bit.
//  FSM RUN: CFG b0=0 -> DRAIN. DRAIN: when rd_out==0 and wr_out==0 -> IDLE, set done.
//   A CFG b0=1 write in DRAIN is ignored.
//  rd_ok = (state==RUN) && rd_out<MAX_OUT; wr_ok is the same with wr_out.
//  rd_out: +1 on fire, -1 on rsp, unchanged if both in one cycle. wr_out likewise.
//   A rsp with count 0 and no fire leaves the count at 0 and sets err sticky.
//   err clears only on reset.
//  Counters: 64-bit clk_cnt (+1 per cycle in RUN or DRAIN), rd_cnt (+1 per rd_rsp),
//   wr_cnt (+1 per wr_rsp). All three saturate at 2^64-1.
//  SNAPSHOT copies all three counters into shadows the cycle after the write.
//  Read map: 0/1/2 shadow clk/rd/wr. 3 status {err[40], done[39], state[38:37],
//   wr_out[36:20], rd_out[16:0]}. 4+i info word i. Any other index reads 0.
//  ch_rst: on RST_CH each set bit i loads a down-counter with RST_CYCLES.
//   ch_rst[i] is high while that counter is nonzero. A rewrite reloads the counter.
//   When ch_rst[i] is high, start_mask[i] is forced low in the same cycle.
//  soft_rst=1 clears state, counters, outstanding counts and masks.
//   It does not clear ws_base, ws_size, shadows or soft_rst itself.
// TESTING
//  Reset then read idx 3 -> 0. Read idx 0 -> 0. rd_ok=0, run=0.
//  CFG=1, 5x rd_req_fire, MAX_OUT=4 -> rd_ok drops after 4th fire; idx3 rd_out=4.
//  RUN, 3 reads outstanding, CFG=0 -> DRAIN with run=0.
//   After 3 rd_rsp -> IDLE next cycle; status done=1.
//  START_SET 0xF, START_CLR 0x5 -> start_mask=0xA.
//   RST_CH 0x2 -> ch_rst[1] high 4 cycles, start_mask[1] low in those cycles.
//  rd_rsp with rd_out=0 -> rd_out stays 0, err=1.
//   Same-cycle fire and rsp at rd_out=2 -> stays 2.
//  Preload clk_cnt near max, run 3 cycles -> 0xFFFF_FFFF_FFFF_FFFF.
//   SNAPSHOT, then read idx 0 -> equals the snapshot value one cycle after the read.

Source files
------------

// File: rtl/afu_csr_ctrl_bank.sv
// afu_csr_ctrl_bank: CSR control/status bank between the CSR manager and
// afu_manager. It decodes configuration writes, serves counter/status/info
// readback, tracks outstanding CCI traffic and runs a RUN->DRAIN->IDLE
// shutdown so the AFU never stops with requests still in flight.
module afu_csr_ctrl_bank #(
  parameter int NUM_CH     = 64,
  parameter int INFO_WORDS = 9,
  parameter int MAX_OUT    = 64,
  parameter int RST_CYCLES = 4,
  parameter int IDX_W      = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     csr_wr_en,
  input  logic [IDX_W-1:0]         csr_wr_idx,
  input  logic [63:0]              csr_wr_data,
  input  logic [IDX_W-1:0]         csr_rd_idx,
  output logic [63:0]              csr_rd_data,
  input  logic [64*INFO_WORDS-1:0] info,
  input  logic                     rd_req_fire,
  input  logic                     rd_rsp,
  input  logic                     wr_req_fire,
  input  logic                     wr_rsp,
  output logic                     run,
  output logic                     soft_rst,
  output logic                     update_ws,
  output logic [63:0]              ws_base,
  output logic [63:0]              ws_size,
  output logic [NUM_CH-1:0]        start_mask,
  output logic [NUM_CH-1:0]        ch_rst,
  output logic                     rd_ok,
  output logic                     wr_ok
);

  localparam int OUT_W = $clog2(MAX_OUT + 1);
  localparam int RC_W  = $clog2(RST_CYCLES + 1);
  localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUT);
  localparam logic [RC_W-1:0]  RC_LOAD = RC_W'(RST_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic              set_done;
  logic              clr_done;
  logic              done;
  logic              err;
  logic [OUT_W-1:0]  rd_out;
  logic [OUT_W-1:0]  wr_out;
  logic [63:0]       clk_cnt;
  logic [63:0]       rd_cnt;
  logic [63:0]       wr_cnt;
  logic [63:0]       shadow_clk;
  logic [63:0]       shadow_rd;
  logic [63:0]       shadow_wr;
  logic [NUM_CH-1:0] mask;
  logic [RC_W-1:0]   rst_cnt [NUM_CH];
  logic [63:0]       rd_mux;
  logic [NUM_CH-1:0] wr_bits;

  logic wr_cfg;
  logic wr_base;
  logic wr_size;
  logic wr_set;
  logic wr_clr;
  logic wr_rst_ch;
  logic wr_snap;

  assign wr_cfg    = csr_wr_en && (csr_wr_idx == IDX_W'(0));
  assign wr_base   = csr_wr_en && (csr_wr_idx == IDX_W'(1));
  assign wr_size   = csr_wr_en && (csr_wr_idx == IDX_W'(2));
  assign wr_set    = csr_wr_en && (csr_wr_idx == IDX_W'(3));
  assign wr_clr    = csr_wr_en && (csr_wr_idx == IDX_W'(4));
  assign wr_rst_ch = csr_wr_en && (csr_wr_idx == IDX_W'(5));
  assign wr_snap   = csr_wr_en && (csr_wr_idx == IDX_W'(6));
  assign wr_bits   = csr_wr_data[NUM_CH-1:0];

  // A fire and a response together cancel; a fire at the limit is not counted
  function automatic logic [OUT_W-1:0] next_out(input logic [OUT_W-1:0] cur,
                                                input logic fire, input logic rsp);
    next_out = cur;
    if (fire && !rsp && cur != OUT_MAX)
      next_out = cur + OUT_W'(1);
    else if (rsp && !fire && cur != '0)
      next_out = cur - OUT_W'(1);
  endfunction

  function automatic logic [63:0] sat_inc(input logic [63:0] v);
    return (v == '1) ? v : v + 64'd1;
  endfunction

  assign run   = (state == RUN);
  assign rd_ok = run && (rd_out < OUT_MAX);
  assign wr_ok = run && (wr_out < OUT_MAX);
  assign start_mask = mask & ~ch_rst;

  // Next-state logic for the run/drain sequence, plus done-flag events
  always_comb begin
    state_next = state;
    set_done   = 1'b0;
    clr_done   = 1'b0;
    case (state)
      IDLE: begin
        if (wr_cfg && csr_wr_data[0]) begin
          state_next = RUN;
          clr_done   = 1'b1;
        end
      end
      RUN: begin
        if (wr_cfg && !csr_wr_data[0])
          state_next = DRAIN;
      end
      DRAIN: begin
        if (rd_out == '0 && wr_out == '0) begin
          state_next = IDLE;
          set_done   = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register; soft reset forces IDLE without touching done
  always_ff @(posedge clk) begin
    if (reset || soft_rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Sticky done (set on drain completion) and err (response with nothing outstanding)
  always_ff @(posedge clk) begin
    if (reset) begin
      done <= 1'b0;
      err  <= 1'b0;
    end else begin
      if (!soft_rst && set_done)
        done <= 1'b1;
      else if (!soft_rst && clr_done)
        done <= 1'b0;
      if ((rd_rsp && !rd_req_fire && rd_out == '0) ||
          (wr_rsp && !wr_req_fire && wr_out == '0))
        err <= 1'b1;
    end
  end

  // Outstanding request tracking and saturating activity counters
  always_ff @(posedge clk) begin
    if (reset || soft_rst) begin
      rd_out  <= '0;
      wr_out  <= '0;
      clk_cnt <= '0;
      rd_cnt  <= '0;
      wr_cnt  <= '0;
    end else begin
      rd_out <= next_out(rd_out, rd_req_fire, rd_rsp);
      wr_out <= next_out(wr_out, wr_req_fire, wr_rsp);
      if (state != IDLE)
        clk_cnt <= sat_inc(clk_cnt);
      if (rd_rsp)
        rd_cnt <= sat_inc(rd_cnt);
      if (wr_rsp)
        wr_cnt <= sat_inc(wr_cnt);
    end
  end

  // Counter shadows and workspace registers survive soft reset
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_clk <= '0;
      shadow_rd  <= '0;
      shadow_wr  <= '0;
      ws_base    <= '0;
      ws_size    <= '0;
      soft_rst   <= 1'b0;
      update_ws  <= 1'b0;
    end else begin
      if (wr_snap) begin
        shadow_clk <= clk_cnt;
        shadow_rd  <= rd_cnt;
        shadow_wr  <= wr_cnt;
      end
      if (wr_base)
        ws_base <= csr_wr_data;
      if (wr_size)
        ws_size <= csr_wr_data;
      if (wr_cfg)
        soft_rst <= csr_wr_data[1];
      update_ws <= wr_cfg && csr_wr_data[2];
    end
  end

  // Start mask set/clear and per-channel reset stretch counters
  always_ff @(posedge clk) begin
    if (reset || soft_rst) begin
      mask <= '0;
      for (int i = 0; i < NUM_CH; i++)
        rst_cnt[i] <= '0;
    end else begin
      if (wr_set)
        mask <= mask | wr_bits;
      else if (wr_clr)
        mask <= mask & ~wr_bits;
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_rst_ch && wr_bits[i])
          rst_cnt[i] <= RC_LOAD;
        else if (rst_cnt[i] != '0)
          rst_cnt[i] <= rst_cnt[i] - RC_W'(1);
      end
    end
  end

  // A channel is held in reset while its stretch counter is running
  always_comb begin
    ch_rst = '0;
    for (int i = 0; i < NUM_CH; i++)
      ch_rst[i] = (rst_cnt[i] != '0);
  end

  // Readback selection: shadows, packed status, then the info words
  always_comb begin
    rd_mux = '0;
    if (csr_rd_idx == IDX_W'(0))
      rd_mux = shadow_clk;
    else if (csr_rd_idx == IDX_W'(1))
      rd_mux = shadow_rd;
    else if (csr_rd_idx == IDX_W'(2))
      rd_mux = shadow_wr;
    else if (csr_rd_idx == IDX_W'(3)) begin
      rd_mux[40]    = err;
      rd_mux[39]    = done;
      rd_mux[38:37] = state;
      rd_mux[36:20] = 17'(wr_out);
      rd_mux[16:0]  = 17'(rd_out);
    end else if (int'(csr_rd_idx) >= 4 && int'(csr_rd_idx) < 4 + INFO_WORDS)
      rd_mux = info[(int'(csr_rd_idx) - 4) * 64 +: 64];
  end

  // Registered read data gives a fixed one-cycle read latency
  always_ff @(posedge clk) begin
    if (reset)
      csr_rd_data <= '0;
    else
      csr_rd_data <= rd_mux;
  end

endmodule

// File: tb/tb_afu_csr_ctrl_bank.sv
// tb_afu_csr_ctrl_bank: directed bench for afu_csr_ctrl_bank with a cycle
// model of the CSR bank and a per-cycle compare process.
module tb_afu_csr_ctrl_bank;

  localparam int NUM_CH     = 8;
  localparam int INFO_WORDS = 3;
  localparam int MAX_OUT    = 4;
  localparam int RST_CYCLES = 4;
  localparam int IDX_W      = 4;

  logic                     clk;
  logic                     reset;
  logic                     csr_wr_en;
  logic [IDX_W-1:0]         csr_wr_idx;
  logic [63:0]              csr_wr_data;
  logic [IDX_W-1:0]         csr_rd_idx;
  logic [63:0]              csr_rd_data;
  logic [64*INFO_WORDS-1:0] info;
  logic                     rd_req_fire;
  logic                     rd_rsp;
  logic                     wr_req_fire;
  logic                     wr_rsp;
  logic                     run;
  logic                     soft_rst;
  logic                     update_ws;
  logic [63:0]              ws_base;
  logic [63:0]              ws_size;
  logic [NUM_CH-1:0]        start_mask;
  logic [NUM_CH-1:0]        ch_rst;
  logic                     rd_ok;
  logic                     wr_ok;

  int checks = 0;
  int errors = 0;

  afu_csr_ctrl_bank #(
    .NUM_CH(NUM_CH), .INFO_WORDS(INFO_WORDS), .MAX_OUT(MAX_OUT),
    .RST_CYCLES(RST_CYCLES), .IDX_W(IDX_W)
  ) dut (
    .clk(clk), .reset(reset),
    .csr_wr_en(csr_wr_en), .csr_wr_idx(csr_wr_idx), .csr_wr_data(csr_wr_data),
    .csr_rd_idx(csr_rd_idx), .csr_rd_data(csr_rd_data), .info(info),
    .rd_req_fire(rd_req_fire), .rd_rsp(rd_rsp),
    .wr_req_fire(wr_req_fire), .wr_rsp(wr_rsp),
    .run(run), .soft_rst(soft_rst), .update_ws(update_ws),
    .ws_base(ws_base), .ws_size(ws_size),
    .start_mask(start_mask), .ch_rst(ch_rst),
    .rd_ok(rd_ok), .wr_ok(wr_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: 0 = idle, 1 = run, 2 = drain
  int          m_state, m_rdo, m_wro;
  int          m_rc [NUM_CH];
  bit          m_done, m_err, m_soft, m_upd;
  bit          m_clk_valid, m_sh_valid, rd_skip;
  bit          clk_unknown;
  logic [63:0] m_clk, m_rdc, m_wrc, m_sh_clk, m_sh_rd, m_sh_wr;
  logic [63:0] m_base, m_size, m_rd;
  logic [NUM_CH-1:0] m_mask;

  initial clk_unknown = 1'b0;

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
    end
  endtask

  function automatic logic [63:0] model_read(input int idx);
    logic [63:0] r;
    r = 64'd0;
    if (idx == 0)      r = m_sh_clk;
    else if (idx == 1) r = m_sh_rd;
    else if (idx == 2) r = m_sh_wr;
    else if (idx == 3)
      r = (64'(m_err) << 40) | (64'(m_done) << 39) | (64'(m_state) << 37) |
          (64'(m_wro) << 20) | 64'(m_rdo);
    else if (idx >= 4 && idx < 4 + INFO_WORDS)
      r = info[(idx - 4) * 64 +: 64];
    return r;
  endfunction

  function automatic logic [NUM_CH-1:0] model_ch_rst();
    logic [NUM_CH-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_CH; i++)
      r[i] = (m_rc[i] > 0);
    return r;
  endfunction

  function automatic int step_out(input int cur, input logic fire, input logic rsp);
    if (fire && !rsp && cur < MAX_OUT) return cur + 1;
    if (rsp && !fire && cur > 0) return cur - 1;
    return cur;
  endfunction

  function automatic logic [63:0] plus_one_sat(input logic [63:0] v);
    return (v == 64'hFFFF_FFFF_FFFF_FFFF) ? v : v + 64'd1;
  endfunction

  // Cycle model: next values are computed from the pre-edge model and inputs
  always @(posedge clk) begin : model
    int          n_state, n_rdo, n_wro;
    bit          n_done, n_err, drained, wcfg;
    logic [63:0] d;
    if (reset) begin
      m_state = 0; m_rdo = 0; m_wro = 0;
      m_done = 0; m_err = 0; m_soft = 0; m_upd = 0;
      m_clk = 0; m_rdc = 0; m_wrc = 0;
      m_sh_clk = 0; m_sh_rd = 0; m_sh_wr = 0;
      m_base = 0; m_size = 0; m_rd = 0; m_mask = '0;
      m_clk_valid = 1; m_sh_valid = 1; rd_skip = 0;
      for (int i = 0; i < NUM_CH; i++) m_rc[i] = 0;
    end else begin
      if (clk_unknown)
        m_clk_valid = 0;
      else if (!m_clk_valid) begin
        m_clk = 64'hFFFF_FFFF_FFFF_FFFF;
        m_clk_valid = 1;
      end
      rd_skip = (csr_rd_idx == 0) && !m_sh_valid;
      m_rd    = model_read(int'(csr_rd_idx));
      d       = csr_wr_data;
      wcfg    = csr_wr_en && csr_wr_idx == 0;
      drained = (m_rdo == 0) && (m_wro == 0);

      n_done  = m_done;
      n_state = m_state;
      if (m_soft) n_state = 0;
      else if (m_state == 0 && wcfg && d[0]) begin n_state = 1; n_done = 0; end
      else if (m_state == 1 && wcfg && !d[0]) n_state = 2;
      else if (m_state == 2 && drained) begin n_state = 0; n_done = 1; end

      n_err = m_err || (rd_rsp && !rd_req_fire && m_rdo == 0) ||
                       (wr_rsp && !wr_req_fire && m_wro == 0);
      n_rdo = m_soft ? 0 : step_out(m_rdo, rd_req_fire, rd_rsp);
      n_wro = m_soft ? 0 : step_out(m_wro, wr_req_fire, wr_rsp);

      if (csr_wr_en && csr_wr_idx == 6) begin
        m_sh_clk = m_clk; m_sh_rd = m_rdc; m_sh_wr = m_wrc;
        m_sh_valid = m_clk_valid;
      end
      if (m_soft) begin
        m_clk = 0; m_rdc = 0; m_wrc = 0;
      end else begin
        if (m_state != 0) m_clk = plus_one_sat(m_clk);
        if (rd_rsp) m_rdc = plus_one_sat(m_rdc);
        if (wr_rsp) m_wrc = plus_one_sat(m_wrc);
      end

      if (csr_wr_en && csr_wr_idx == 1) m_base = d;
      if (csr_wr_en && csr_wr_idx == 2) m_size = d;

      if (m_soft) begin
        m_mask = '0;
        for (int i = 0; i < NUM_CH; i++) m_rc[i] = 0;
      end else begin
        if (csr_wr_en && csr_wr_idx == 3) m_mask = m_mask | d[NUM_CH-1:0];
        if (csr_wr_en && csr_wr_idx == 4) m_mask = m_mask & ~d[NUM_CH-1:0];
        for (int i = 0; i < NUM_CH; i++) begin
          if (csr_wr_en && csr_wr_idx == 5 && d[i]) m_rc[i] = RST_CYCLES;
          else if (m_rc[i] > 0) m_rc[i] = m_rc[i] - 1;
        end
      end

      m_upd   = wcfg && d[2];
      m_soft  = wcfg ? d[1] : m_soft;
      m_state = n_state;
      m_done  = n_done;
      m_err   = n_err;
      m_rdo   = n_rdo;
      m_wro   = n_wro;
    end
  end

  // Compare every output against the model shortly after each edge
  always @(posedge clk) begin
    #1;
    check_output("run", 64'(run), 64'(m_state == 1));
    check_output("rd_ok", 64'(rd_ok), 64'(m_state == 1 && m_rdo < MAX_OUT));
    check_output("wr_ok", 64'(wr_ok), 64'(m_state == 1 && m_wro < MAX_OUT));
    check_output("soft_rst", 64'(soft_rst), 64'(m_soft));
    check_output("update_ws", 64'(update_ws), 64'(m_upd));
    check_output("ws_base", ws_base, m_base);
    check_output("ws_size", ws_size, m_size);
    check_output("ch_rst", 64'(ch_rst), 64'(model_ch_rst()));
    check_output("start_mask", 64'(start_mask), 64'(m_mask & ~model_ch_rst()));
    if (!rd_skip)
      check_output("csr_rd_data", csr_rd_data, m_rd);
  end

  task automatic csr_write(input int idx, input logic [63:0] data);
    csr_wr_en   = 1'b1;
    csr_wr_idx  = IDX_W'(idx);
    csr_wr_data = data;
    @(negedge clk);
    csr_wr_en   = 1'b0;
  endtask

  task automatic csr_read(input int idx, output logic [63:0] data);
    csr_rd_idx = IDX_W'(idx);
    @(negedge clk);
    data = csr_rd_data;
  endtask

  task automatic apply_stimulus(input logic rf, input logic rr,
                                input logic wf, input logic wrs);
    rd_req_fire = rf; rd_rsp = rr; wr_req_fire = wf; wr_rsp = wrs;
    @(negedge clk);
    rd_req_fire = 0; rd_rsp = 0; wr_req_fire = 0; wr_rsp = 0;
  endtask

  initial begin : watchdog
    #100000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : stimulus
    logic [63:0] v;
    reset = 1; csr_wr_en = 0; csr_wr_idx = 0; csr_wr_data = 0; csr_rd_idx = 0;
    rd_req_fire = 0; rd_rsp = 0; wr_req_fire = 0; wr_rsp = 0;
    info = {64'hCCCC_0000_1111_2222, 64'hBBBB_3333_4444_5555, 64'hAAAA_6666_7777_8888};
    repeat (3) @(negedge clk);
    reset = 0;

    $display("[TB] reset state");
    csr_read(3, v);  check_output("status after reset", v, 64'h0);
    csr_read(0, v);  check_output("shadow clk after reset", v, 64'h0);
    check_output("rd_ok after reset", 64'(rd_ok), 64'h0);
    check_output("run after reset", 64'(run), 64'h0);

    $display("[TB] outstanding limit");
    csr_write(0, 64'h1);
    check_output("run after CFG=1", 64'(run), 64'h1);
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1, 0, 0, 0);
      if (i == 2) check_output("rd_ok after 3 fires", 64'(rd_ok), 64'h1);
      if (i == 3) check_output("rd_ok after 4 fires", 64'(rd_ok), 64'h0);
    end
    csr_read(3, v);  check_output("status rd_out=4", v, 64'h0000_0020_0000_0004);

    $display("[TB] drain sequence");
    apply_stimulus(0, 1, 0, 0);
    csr_write(0, 64'h0);
    check_output("run in DRAIN", 64'(run), 64'h0);
    rd_rsp = 1;
    csr_write(0, 64'h1);
    @(negedge clk);
    @(negedge clk);
    rd_rsp = 0;
    check_output("run stays low in DRAIN", 64'(run), 64'h0);
    @(negedge clk);
    csr_read(3, v);  check_output("status after drain", v, 64'h0000_0080_0000_0000);

    $display("[TB] start mask and channel reset");
    csr_write(3, 64'hFF0F);
    csr_write(4, 64'h5);
    check_output("start_mask set/clr", 64'(start_mask), 64'h0A);
    csr_write(5, 64'h2);
    for (int i = 0; i < RST_CYCLES; i++) begin
      check_output("ch_rst stretched", 64'(ch_rst), 64'h02);
      check_output("start_mask gated", 64'(start_mask), 64'h08);
      @(negedge clk);
    end
    check_output("ch_rst released", 64'(ch_rst), 64'h00);
    check_output("start_mask restored", 64'(start_mask), 64'h0A);

    $display("[TB] response errors and cancelling fire/rsp");
    apply_stimulus(0, 1, 0, 0);
    csr_read(3, v);  check_output("status err set", v, 64'h0000_0180_0000_0000);
    csr_write(0, 64'h1);
    apply_stimulus(1, 0, 1, 0);
    apply_stimulus(1, 0, 0, 0);
    apply_stimulus(1, 1, 0, 0);
    csr_read(3, v);  check_output("status fire+rsp", v, 64'h0000_0120_0010_0002);

    $display("[TB] clock counter saturation");
    clk_unknown = 1;
    force dut.clk_cnt = 64'hFFFF_FFFF_FFFF_FFFD;
    @(negedge clk);
    release dut.clk_cnt;
    repeat (4) @(negedge clk);
    clk_unknown = 0;
    csr_write(6, 64'h0);
    csr_read(0, v);  check_output("shadow clk saturated", v, 64'hFFFF_FFFF_FFFF_FFFF);
    csr_read(1, v);  check_output("shadow rd_cnt", v, 64'd6);

    $display("[TB] workspace, soft reset and info");
    csr_write(1, 64'h0000_1234_5678_9000);
    csr_write(2, 64'h0000_0000_0040_0000);
    csr_write(0, 64'h5);
    check_output("update_ws pulse", 64'(update_ws), 64'h1);
    @(negedge clk);
    check_output("update_ws ends", 64'(update_ws), 64'h0);
    csr_write(0, 64'h2);
    check_output("soft_rst level", 64'(soft_rst), 64'h1);
    @(negedge clk);
    check_output("start_mask soft cleared", 64'(start_mask), 64'h0);
    csr_write(0, 64'h0);
    csr_read(3, v);  check_output("status after soft reset", v, 64'h0000_0100_0000_0000);
    check_output("ws_base kept", ws_base, 64'h0000_1234_5678_9000);
    csr_read(6, v);  check_output("info word 2", v, 64'hCCCC_0000_1111_2222);
    csr_read(7, v);  check_output("unmapped idx 7", v, 64'h0);
    csr_read(15, v); check_output("unmapped idx 15", v, 64'h0);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
